// File: rtl/ram_arbiter_pkg.sv
// Shared encodings and helpers for the two-port RAM arbiter.
package ram_arbiter_pkg;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  localparam logic [31:0] DEFAULT_ABORT_DATA = 32'hDEADBEEF;

  typedef struct packed {
    logic        valid;
    logic        is_write;
    logic [31:0] address;
    logic [31:0] wdata;
  } slot_t;

  // A lone candidate wins; a tie goes to the port that was not granted last.
  function automatic logic pick_port(input logic c0, input logic c1, input logic last);
    if (c0 && c1) return ~last;
    else if (c1) return PORT1;
    else return PORT0;
  endfunction

endpackage

// File: rtl/ram_arbiter_port_slot.sv
// Per-port pending request slot; exposes either the held request or the
// request arriving this cycle as the port's arbitration candidate.
module ram_arb_port_slot
  import ram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        i_readReq,
  input  logic        i_writeReq,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  input  logic        i_clear,
  output slot_t       o_cand
);

  slot_t r_slot;

  // A pulse is only seen while the slot is empty; read+write together is a write.
  always_comb begin
    o_cand = r_slot;
    if (!r_slot.valid) begin
      o_cand.valid    = i_readReq | i_writeReq;
      o_cand.is_write = i_writeReq;
      o_cand.address  = i_address;
      o_cand.wdata    = i_wdata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_slot <= '0;
    end else if (i_clear) begin
      r_slot.valid <= 1'b0;
    end else if (!r_slot.valid && o_cand.valid) begin
      r_slot <= o_cand;
    end
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-port round-robin arbiter in front of a single-transaction RAM, with
// an optional WAIT timeout that aborts the transaction back to the requester.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT    = 64,
  parameter logic [31:0] ABORT_DATA = DEFAULT_ABORT_DATA
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] p0_address,
  input  logic [31:0] p0_wdata,
  input  logic        p0_readReq,
  input  logic        p0_writeReq,
  output logic [31:0] p0_rdata,
  output logic        p0_readAck,
  output logic        p0_writeAck,
  input  logic [31:0] p1_address,
  input  logic [31:0] p1_wdata,
  input  logic        p1_readReq,
  input  logic        p1_writeReq,
  output logic [31:0] p1_rdata,
  output logic        p1_readAck,
  output logic        p1_writeAck,
  output logic [31:0] ramAddress,
  output logic [31:0] ramOut,
  output logic        readReq,
  output logic        writeReq,
  input  logic [31:0] ramIn,
  input  logic        readAck,
  input  logic        writeAck,
  output logic        grantPort,
  output logic        timeoutErr
);

  logic [0:0]  r_state;
  logic        r_last;
  logic        r_is_write;
  logic [31:0] r_cnt;

  slot_t       w_cand0;
  slot_t       w_cand1;
  slot_t       w_sel;
  logic        w_grant;
  logic        w_gport;
  logic        w_clr0;
  logic        w_clr1;
  logic        w_ram_done;
  logic        w_timeout;
  logic [31:0] w_rd_data;

  ram_arb_port_slot u_slot0 (
    .clk        (clk),
    .reset      (reset),
    .i_readReq  (p0_readReq),
    .i_writeReq (p0_writeReq),
    .i_address  (p0_address),
    .i_wdata    (p0_wdata),
    .i_clear    (w_clr0),
    .o_cand     (w_cand0)
  );

  ram_arb_port_slot u_slot1 (
    .clk        (clk),
    .reset      (reset),
    .i_readReq  (p1_readReq),
    .i_writeReq (p1_writeReq),
    .i_address  (p1_address),
    .i_wdata    (p1_wdata),
    .i_clear    (w_clr1),
    .o_cand     (w_cand1)
  );

  always_comb begin
    w_grant = (r_state == ST_IDLE) && (w_cand0.valid || w_cand1.valid);
    w_gport = pick_port(w_cand0.valid, w_cand1.valid, r_last);
    w_sel   = (w_gport == PORT1) ? w_cand1 : w_cand0;
    w_clr0  = w_grant && (w_gport == PORT0);
    w_clr1  = w_grant && (w_gport == PORT1);
  end

  // Only the ack matching the issued type completes; ack beats a same-edge timeout.
  always_comb begin
    w_ram_done = r_is_write ? writeAck : readAck;
    w_timeout  = (TIMEOUT != 0) && ((r_cnt + 32'd1) == TIMEOUT);
    w_rd_data  = w_ram_done ? ramIn : ABORT_DATA;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_last      <= PORT1;
      r_is_write  <= 1'b0;
      r_cnt       <= '0;
      ramAddress  <= '0;
      ramOut      <= '0;
      readReq     <= 1'b0;
      writeReq    <= 1'b0;
      p0_rdata    <= '0;
      p0_readAck  <= 1'b0;
      p0_writeAck <= 1'b0;
      p1_rdata    <= '0;
      p1_readAck  <= 1'b0;
      p1_writeAck <= 1'b0;
      grantPort   <= 1'b0;
      timeoutErr  <= 1'b0;
    end else begin
      readReq     <= 1'b0;
      writeReq    <= 1'b0;
      p0_readAck  <= 1'b0;
      p0_writeAck <= 1'b0;
      p1_readAck  <= 1'b0;
      p1_writeAck <= 1'b0;
      if (r_state == ST_IDLE) begin
        if (w_grant) begin
          ramAddress <= w_sel.address;
          ramOut     <= w_sel.wdata;
          readReq    <= ~w_sel.is_write;
          writeReq   <= w_sel.is_write;
          r_is_write <= w_sel.is_write;
          r_last     <= w_gport;
          grantPort  <= w_gport;
          r_cnt      <= '0;
          r_state    <= ST_WAIT;
        end
      end else if (w_ram_done || w_timeout) begin
        r_state <= ST_IDLE;
        if (!w_ram_done) timeoutErr <= 1'b1;
        if (r_is_write) begin
          if (grantPort == PORT1) p1_writeAck <= 1'b1;
          else p0_writeAck <= 1'b1;
        end else if (grantPort == PORT1) begin
          p1_readAck <= 1'b1;
          p1_rdata   <= w_rd_data;
        end else begin
          p0_readAck <= 1'b1;
          p0_rdata   <= w_rd_data;
        end
      end else begin
        r_cnt <= r_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Scoreboard bench for ram_arbiter: request-level model of the two ports,
// round-robin ordering, RAM latency and timeout, checked by two monitors.
`timescale 1ns/1ps
module tb_ram_arbiter;

  localparam int unsigned TO    = 4;
  localparam logic [31:0] ABORT = 32'hDEADBEEF;

  logic        clk;
  logic        reset;
  logic [31:0] p0_address, p0_wdata, p1_address, p1_wdata;
  logic        p0_readReq, p0_writeReq, p1_readReq, p1_writeReq;
  logic [31:0] p0_rdata, p1_rdata;
  logic        p0_readAck, p0_writeAck, p1_readAck, p1_writeAck;
  logic [31:0] ramAddress, ramOut, ramIn;
  logic        readReq, writeReq, readAck, writeAck, grantPort, timeoutErr;

  ram_arbiter #(.TIMEOUT(TO), .ABORT_DATA(ABORT)) dut (
    .clk(clk), .reset(reset),
    .p0_address(p0_address), .p0_wdata(p0_wdata),
    .p0_readReq(p0_readReq), .p0_writeReq(p0_writeReq),
    .p0_rdata(p0_rdata), .p0_readAck(p0_readAck), .p0_writeAck(p0_writeAck),
    .p1_address(p1_address), .p1_wdata(p1_wdata),
    .p1_readReq(p1_readReq), .p1_writeReq(p1_writeReq),
    .p1_rdata(p1_rdata), .p1_readAck(p1_readAck), .p1_writeAck(p1_writeAck),
    .ramAddress(ramAddress), .ramOut(ramOut),
    .readReq(readReq), .writeReq(writeReq),
    .ramIn(ramIn), .readAck(readAck), .writeAck(writeAck),
    .grantPort(grantPort), .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { bit is_write; logic [31:0] addr; logic [31:0] wdata; int edge_no; } iss_t;
  typedef struct { bit is_write; bit aborted; logic [31:0] data; } rsp_t;

  iss_t iq[2][$];
  rsp_t pq[2][$];

  int cyc = 0;
  int checks = 0;
  int failures = 0;
  bit busy[2];
  int done_edge[2];
  int free_edge;
  bit rr_last;
  bit model_err;
  bit silent;
  int ram_k;
  bit in_txn;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] ram_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h12345678;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    failures++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " ctl"}, 32'({readReq, writeReq, p0_readAck, p0_writeAck,
                           p1_readAck, p1_writeAck, grantPort, timeoutErr}), 32'd0);
    chk({tag, " ramAddress"}, ramAddress, 32'd0);
    chk({tag, " ramOut"}, ramOut, 32'd0);
    chk({tag, " p0_rdata"}, p0_rdata, 32'd0);
    chk({tag, " p1_rdata"}, p1_rdata, 32'd0);
  endtask

  // Stage a request pulse on port p for the next rising edge.
  task automatic arm(input int p, input bit rd, input bit wr,
                     input logic [31:0] a, input logic [31:0] d);
    iss_t it;
    rsp_t rs;
    it.is_write = wr; it.addr = a; it.wdata = d; it.edge_no = cyc + 1;
    rs.is_write = wr; rs.aborted = silent;
    rs.data = silent ? ABORT : ram_word(a);
    iq[p].push_back(it);
    pq[p].push_back(rs);
    busy[p] = 1'b1;
    if (p == 0) begin
      p0_readReq = rd; p0_writeReq = wr; p0_address = a; p0_wdata = d;
    end else begin
      p1_readReq = rd; p1_writeReq = wr; p1_address = a; p1_wdata = d;
    end
  endtask

  task automatic fire();
    @(posedge clk);
    #1;
    p0_readReq = 1'b0; p0_writeReq = 1'b0;
    p1_readReq = 1'b0; p1_writeReq = 1'b0;
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((busy[0] || busy[1] || in_txn) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (busy[0] || busy[1] || in_txn) flag({name, " completion timeout"});
  endtask

  task automatic wait_txn(input string name);
    int n;
    n = 0;
    while (!in_txn && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!in_txn) flag({name, " no RAM request"});
  endtask

  task automatic clear_model();
    for (int p = 0; p < 2; p++) begin
      iq[p].delete();
      pq[p].delete();
      busy[p] = 1'b0;
    end
    rr_last = 1'b1;
    model_err = 1'b0;
  endtask

  // RAM side: check each issued request against the pending requests and
  // round-robin rule, then answer after a chosen latency (or stay silent).
  task automatic ram_txn();
    int e, k, p;
    bit c0, c1;
    iss_t it;
    e = cyc;
    c0 = (iq[0].size() > 0) && (iq[0][0].edge_no <= e);
    c1 = (iq[1].size() > 0) && (iq[1][0].edge_no <= e);
    if (!c0 && !c1) begin
      flag("spurious RAM request");
      return;
    end
    p = (c0 && c1) ? (rr_last ? 0 : 1) : (c1 ? 1 : 0);
    chk("grantPort", 32'(grantPort), 32'(p));
    chk("both RAM reqs", 32'(readReq & writeReq), 32'd0);
    chk("one outstanding", 32'(e >= free_edge), 32'd1);
    it = iq[p].pop_front();
    rr_last = (p == 1);
    chk("writeReq type", 32'(writeReq), 32'(it.is_write));
    chk("ramAddress", ramAddress, it.addr);
    if (it.is_write) chk("ramOut", ramOut, it.wdata);
    in_txn = 1'b1;
    if (silent) begin
      done_edge[p] = e + int'(TO);
      for (int i = 1; i <= int'(TO) + 1; i++) begin
        @(negedge clk);
        chk("req pulse width", 32'(readReq | writeReq), 32'd0);
      end
      if (it.is_write) writeAck = 1'b1; else readAck = 1'b1;
      ramIn = 32'h0BAD0BAD;
      @(negedge clk);
      readAck = 1'b0; writeAck = 1'b0;
      free_edge = e + int'(TO) + 1;
    end else begin
      k = (ram_k > 0) ? ram_k : int'($urandom_range(1, TO));
      done_edge[p] = e + k;
      for (int i = 1; i <= k; i++) begin
        if (i == k) begin
          if (it.is_write) writeAck = 1'b1;
          else begin readAck = 1'b1; ramIn = ram_word(it.addr); end
        end else if ($urandom_range(0, 3) == 0) begin
          if (it.is_write) readAck = 1'b1; else writeAck = 1'b1;
          ramIn = $urandom;
        end
        @(negedge clk);
        readAck = 1'b0; writeAck = 1'b0; ramIn = $urandom;
        chk("req pulse width", 32'(readReq | writeReq), 32'd0);
      end
      free_edge = e + k + 1;
    end
    in_txn = 1'b0;
  endtask

  initial begin : ram_side
    readAck = 1'b0; writeAck = 1'b0; ramIn = '0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (readReq || writeReq) ram_txn();
        else if (cyc >= free_edge) begin
          for (int p = 0; p < 2; p++)
            if (iq[p].size() > 0 && iq[p][0].edge_no <= cyc)
              flag($sformatf("p%0d request not granted at edge %0d", p, cyc));
        end
      end
    end
  end

  task automatic mon_port(input int p);
    logic ra, wa;
    logic [31:0] rd;
    rsp_t rs;
    ra = (p == 1) ? p1_readAck : p0_readAck;
    wa = (p == 1) ? p1_writeAck : p0_writeAck;
    rd = (p == 1) ? p1_rdata : p0_rdata;
    if (ra || wa) begin
      if (pq[p].size() == 0) begin
        flag($sformatf("p%0d unexpected ack", p));
        return;
      end
      rs = pq[p].pop_front();
      busy[p] = 1'b0;
      chk($sformatf("p%0d writeAck type", p), 32'(wa), 32'(rs.is_write));
      chk($sformatf("p%0d both acks", p), 32'(ra & wa), 32'd0);
      if (!rs.is_write) chk($sformatf("p%0d rdata", p), rd, rs.data);
      chk($sformatf("p%0d ack edge", p), 32'(cyc), 32'(done_edge[p]));
      if (rs.aborted) model_err = 1'b1;
      chk("timeoutErr", 32'(timeoutErr), 32'(model_err));
    end
  endtask

  initial begin : port_side
    forever begin
      @(negedge clk);
      if (!reset) begin
        for (int p = 0; p < 2; p++) mon_port(p);
      end
    end
  end

  initial begin : main
    int r;
    reset = 1'b0;
    p0_address = '0; p0_wdata = '0; p0_readReq = 1'b0; p0_writeReq = 1'b0;
    p1_address = '0; p1_wdata = '0; p1_readReq = 1'b0; p1_writeReq = 1'b0;
    silent = 1'b0; ram_k = 0; free_edge = 0; in_txn = 1'b0;
    clear_model();
    #1 reset = 1'b1;
    #1 chk_zero("in reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    chk_zero("after reset");

    // First tie after reset goes to p0, the next tie to p1.
    arm(0, 1'b1, 1'b0, 32'h20, 32'h0);
    arm(1, 1'b0, 1'b1, 32'h30, 32'hAA);
    fire(); wait_quiet("tie1");
    arm(0, 1'b0, 1'b1, 32'h40, 32'h55);
    arm(1, 1'b1, 1'b0, 32'h50, 32'h0);
    fire(); wait_quiet("tie2");

    ram_k = 2;
    arm(0, 1'b1, 1'b0, 32'h10, 32'h0);
    fire(); wait_quiet("single read");

    ram_k = 3;
    arm(0, 1'b1, 1'b0, 32'h60, 32'h0);
    fire(); wait_txn("overlap p0");
    arm(1, 1'b0, 1'b1, 32'h70, 32'h1234);
    fire(); wait_quiet("overlap p1");

    ram_k = 1;
    arm(0, 1'b1, 1'b1, 32'h80, 32'hCAFE);
    fire(); wait_quiet("read+write pulse");

    ram_k = 0;
    for (int n = 0; n < 600; n++) begin
      for (int p = 0; p < 2; p++) begin
        if (!busy[p] && $urandom_range(0, 2) == 0) begin
          r = int'($urandom_range(0, 4));
          arm(p, (r < 2) || (r == 4), r >= 2, $urandom, $urandom);
        end
      end
      fire();
    end
    wait_quiet("random");

    silent = 1'b1;
    arm(0, 1'b1, 1'b0, 32'h90, 32'h0);
    fire(); wait_quiet("abort read");
    chk("timeoutErr sticky", 32'(timeoutErr), 32'd1);
    arm(1, 1'b0, 1'b1, 32'hA0, 32'h77);
    fire(); wait_quiet("abort write");

    arm(0, 1'b1, 1'b0, 32'hB0, 32'h0);
    fire(); wait_txn("reset txn");
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk_zero("mid-wait reset");
    clear_model();
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
    wait_quiet("late ack");

    silent = 1'b0; ram_k = 2;
    arm(1, 1'b1, 1'b0, 32'hC0, 32'h0);
    fire(); wait_quiet("after reset");
    arm(0, 1'b0, 1'b1, 32'hD0, 32'h99);
    arm(1, 1'b0, 1'b1, 32'hE0, 32'h66);
    fire(); wait_quiet("tie after reset");

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
